rv32i_mem_arbiter: RTL and testbench

//  Shares one single-ported memory between the RV32I instruction-fetch port and the load/store port.

---
 rtl/rv32i_mem_arbiter.sv | 115 +++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-ported memory between the RV32I fetch and load/store ports.
// Data has priority; a burst counter guarantees fetch a slot; stuck accesses time out with bus_err.
//
// state  | meaning
// IDLE   | no access in flight; arbitrates and latches the winner at the clock edge
// BUSY_I | fetch access presented on mem_*; waits for mem_ready or timeout
// BUSY_D | load/store access presented on mem_*; waits for mem_ready or timeout
module rv32i_mem_arbiter #(
  parameter int n         = 32,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [n-1:0] if_addr,
  output logic         if_ack,
  output logic [n-1:0] if_rdata,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [3:0]   d_be,
  input  logic [n-1:0] d_addr,
  input  logic [n-1:0] d_wdata,
  output logic         d_ack,
  output logic [n-1:0] d_rdata,
  output logic         bus_err,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [3:0]   mem_be,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [n-1:0] mem_rdata
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] burst_cnt;
  logic          busy;
  logic          tmo_hit;
  logic          done;
  logic          fetch_turn;

  assign busy       = (state != IDLE);
  assign tmo_hit    = (TIMEOUT > 0) && (tmo_cnt == TMO_MAX);
  assign done       = busy && (mem_ready || tmo_hit);
  // A real mem_ready on the timeout cycle is a normal completion.
  assign bus_err    = busy && tmo_hit && !mem_ready;
  assign if_ack     = (state == BUSY_I) && done;
  assign d_ack      = (state == BUSY_D) && done;
  assign if_rdata   = bus_err ? '0 : mem_rdata;
  assign d_rdata    = bus_err ? '0 : mem_rdata;
  assign stall      = (if_req | d_req) & ~(if_ack | d_ack);
  assign fetch_turn = if_req && (burst_cnt == BURST_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tmo_cnt   <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !fetch_turn) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_we ? d_be : 4'b0000;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            tmo_cnt   <= '0;
          end else if (if_req) begin
            state    <= BUSY_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_be   <= 4'b0000;
            mem_addr <= if_addr;
            tmo_cnt  <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            // Count data wins only while fetch is actually waiting.
            if (state == BUSY_D && if_req)
              burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BW'(1);
            else
              burst_cnt <= '0;
          end else if (TIMEOUT > 0) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: fetch, priority, burst fairness, timeout and reset cases.
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        if_ack, d_ack, bus_err, stall, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  rv32i_mem_arbiter #(.n(32), .MAX_BURST(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .bus_err(bus_err), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected grant order with data and fetch both held: four data wins, one fetch, then data.
  logic [5:0] exp_is_d = 6'b101111;

  initial begin
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;

    @(negedge clk);
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_acks", {if_ack, d_ack, bus_err}, 0);
    check_val("rst_stall", stall, 0);
    next_cyc();
    rst = 1'b0;

    // Fetch only, memory always ready
    if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h13;
    @(negedge clk);
    check_val("f_c0_req", mem_req, 0);
    check_val("f_c0_stall", stall, 1);
    next_cyc();
    @(negedge clk);
    check_val("f_c1_req", mem_req, 1);
    check_val("f_c1_addr", mem_addr, 32'h100);
    check_val("f_c1_we", mem_we, 0);
    check_val("f_c1_ack", if_ack, 1);
    check_val("f_c1_rdata", if_rdata, 32'h13);
    check_val("f_c1_stall", stall, 0);
    next_cyc();
    if_addr = 32'h104; mem_rdata = 32'h93;
    @(negedge clk);
    check_val("f_c2_idle", {mem_req, if_ack}, 0);
    next_cyc();
    @(negedge clk);
    check_val("f_c3_ack", if_ack, 1);
    check_val("f_c3_addr", mem_addr, 32'h104);
    next_cyc();
    if_req = 0;
    next_cyc();

    // Simultaneous store and fetch: data wins first
    if_req = 1; if_addr = 32'h200;
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    next_cyc();
    @(negedge clk);
    check_val("s_d_ack", {d_ack, if_ack}, 2'b10);
    check_val("s_d_we", mem_we, 1);
    check_val("s_d_addr", mem_addr, 32'h2000);
    check_val("s_d_wdata", mem_wdata, 32'hDEADBEEF);
    check_val("s_d_be", mem_be, 4'hF);
    check_val("s_d_stall", stall, 0);
    next_cyc();
    d_req = 0; d_we = 0;
    @(negedge clk);
    check_val("s_gap_stall", stall, 1);
    next_cyc();
    @(negedge clk);
    check_val("s_i_ack", {d_ack, if_ack}, 2'b01);
    check_val("s_i_we", {mem_req, mem_we}, 2'b10);
    check_val("s_i_be", mem_be, 4'h0);
    check_val("s_i_addr", mem_addr, 32'h200);
    next_cyc();
    if_req = 0;
    next_cyc();

    // Both held continuously: fetch must get a slot after MAX_BURST data grants
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h4000; mem_rdata = 32'hA5A5;
    for (int k = 0; k < 6; k++) begin
      next_cyc();
      @(negedge clk);
      check_val($sformatf("b_grant%0d", k), {d_ack, if_ack},
                exp_is_d[k] ? 2'b10 : 2'b01);
      check_val($sformatf("b_addr%0d", k), mem_addr, exp_is_d[k] ? 32'h4000 : 32'h300);
      if (k == 0) begin
        check_val("b_load_be", mem_be, 4'h0);
        check_val("b_load_rdata", d_rdata, 32'hA5A5);
      end
      next_cyc();
    end
    if_req = 0; d_req = 0;
    next_cyc();

    // Timeout: memory never ready, TIMEOUT=8
    d_req = 1; d_we = 0; d_addr = 32'h5000; mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
    next_cyc();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_val($sformatf("t_wait%0d", k), {mem_req, d_ack, bus_err, stall}, 4'b1001);
      next_cyc();
    end
    @(negedge clk);
    check_val("t_ack_err", {d_ack, bus_err}, 2'b11);
    check_val("t_rdata", d_rdata, 0);
    check_val("t_stall", stall, 0);
    next_cyc();
    d_req = 0; mem_ready = 1;
    @(negedge clk);
    check_val("t_late_ready", {mem_req, d_ack, bus_err}, 0);
    next_cyc();

    // Reset asserted mid-access
    mem_ready = 0;
    d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h6000; d_wdata = 32'h55;
    next_cyc();
    @(negedge clk);
    check_val("r_busy", {mem_req, mem_we}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check_val("r_async_drop", {mem_req, d_ack, bus_err}, 0);
    next_cyc();
    check_val("r_held_no_ack", {mem_req, d_ack}, 0);
    d_req = 0; d_we = 0;
    rst = 1'b0;
    if_req = 1; if_addr = 32'h700; mem_ready = 1; mem_rdata = 32'h77;
    next_cyc();
    @(negedge clk);
    check_val("r_fresh_ack", {if_ack, d_ack}, 2'b10);
    check_val("r_fresh_addr", mem_addr, 32'h700);
    next_cyc();
    if_req = 0;
    next_cyc();

    // mem_ready arriving exactly on the timeout cycle completes normally
    d_req = 1; d_addr = 32'h7000; mem_ready = 0; mem_rdata = 32'h1234;
    next_cyc();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_val($sformatf("e_wait%0d", k), {d_ack, stall}, 2'b01);
      next_cyc();
    end
    mem_ready = 1;
    @(negedge clk);
    check_val("e_ack", {d_ack, bus_err}, 2'b10);
    check_val("e_rdata", d_rdata, 32'h1234);
    check_val("e_stall", stall, 0);
    next_cyc();
    d_req = 0;
    @(negedge clk);
    check_val("e_idle", {mem_req, d_ack, stall}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
